// File: rtl/overlay_fetch_pkg.sv
// Shared types and constants for the overlay background fetcher.
package overlay_fetch_pkg;

    // Fetch sequencer states; at most one SDRAM read is in flight outside IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // ARGB4444 word layout {a,b,g,r}, 4 bits per field.
    localparam int DATA_W  = 16;
    localparam int FIELD_W = 4;
    localparam int R_OFS   = 0;
    localparam int G_OFS   = 4;
    localparam int B_OFS   = 8;
    localparam int A_OFS   = 12;

    // Byte-address increment per fetched word.
    localparam int STEP_HI = 2;  // full resolution
    localparam int STEP_LO = 4;  // low resolution skips every other word

endpackage

// File: rtl/overlay_fifo.sv
// Prefetch buffer: power-of-two circular FIFO with flush and
// simultaneous push/pop at full.
module overlay_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wptr_q - rptr_q;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q[PW-1:0]];

    // Next pointer values; flush wins over any push or pop in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/overlay_fetch.sv
// Overlay background fetcher: streams ARGB4444 words from SDRAM into a
// prefetch FIFO and emits one pixel per active ce_pix.
module overlay_fetch
    import overlay_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              lowres,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vsync,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic [3:0]        pix_a,
    output logic [3:0]        pix_r,
    output logic [3:0]        pix_g,
    output logic [3:0]        pix_b,
    output logic              underflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 2;

    fetch_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d, step;
    logic                     mem_req_q, mem_req_d;
    logic [DATA_W-1:0]        pix_q, pix_d;
    logic                     underflow_q, underflow_d;
    logic                     vsync_q, vsync_d;

    logic                     vs_edge, pop_due, ack_ok, fetch_ok;
    logic [CW-1:0]            occ;
    logic                     fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]        fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign vsync_d    = ce_pix ? vsync : vsync_q;
    assign vs_edge    = ce_pix && vsync && !vsync_q;
    assign pop_due    = enable && ce_pix && !(hblank || vblank);
    assign fifo_pop   = pop_due && !fifo_empty;
    // A stale ack (frame restart or disable in the same cycle) is never stored.
    assign ack_ok     = (state_q == S_WAIT) && mem_ack && enable && !vs_edge;
    assign fifo_push  = ack_ok && (!fifo_full || fifo_pop);
    assign fifo_flush = !enable || vs_edge;
    assign step       = lowres ? ADDR_W'(STEP_LO) : ADDR_W'(STEP_HI);
    // Occupancy reserves a slot for the read in flight.
    assign occ        = CW'(fifo_count) + CW'(state_q != S_IDLE);
    assign fetch_ok   = (occ < CW'(FIFO_DEPTH)) || vs_edge;

    overlay_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (mem_data),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state logic for the fetch sequencer, address counter and pixel output.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_d       = pix_q;
        underflow_d = underflow_q;
        if (!enable) begin
            addr_d      = '0;
            pix_d       = '0;
            underflow_d = 1'b0;
            // A strobe already on the bus still owes an ack; absorb it in DRAIN
            // so a later re-enable cannot put two reads in flight.
            if (state_q == S_REQ || ((state_q == S_WAIT || state_q == S_DRAIN) && !mem_ack))
                state_d = S_DRAIN;
            else
                state_d = S_IDLE;
        end else begin
            if (pop_due) begin
                if (!fifo_empty) begin
                    pix_d = fifo_dout;
                end else begin
                    pix_d       = '0;
                    underflow_d = 1'b1;
                end
            end
            if (vs_edge)     addr_d = '0;
            else if (ack_ok) addr_d = addr_q + step;  // wraps modulo 2^ADDR_W
            case (state_q)
                S_IDLE:  if (fetch_ok) state_d = S_REQ;
                S_REQ:   state_d = vs_edge ? S_DRAIN : S_WAIT;
                S_WAIT:  if (mem_ack) state_d = S_IDLE;
                         else if (vs_edge) state_d = S_DRAIN;
                S_DRAIN: if (mem_ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mem_req_d = (state_d == S_REQ);

    // Sequencer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            pix_q       <= '0;
            underflow_q <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_req_q   <= mem_req_d;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
            vsync_q     <= vsync_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = addr_q;
    assign underflow = underflow_q;
    assign pix_a     = pix_q[A_OFS +: FIELD_W];
    assign pix_r     = pix_q[R_OFS +: FIELD_W];
    assign pix_g     = pix_q[G_OFS +: FIELD_W];
    assign pix_b     = pix_q[B_OFS +: FIELD_W];

endmodule

// File: tb/tb_overlay_fetch.sv
// Bench for overlay_fetch. A narrow address width makes the address wrap
// reachable in a short run; a standalone FIFO instance covers push+pop at full.
module tb_overlay_fetch;
    localparam int AW    = 6;
    localparam int DEPTH = 8;

    logic clk = 0, reset_n = 0, enable = 0, lowres = 0, ce_pix = 0;
    logic hblank = 1, vblank = 1, vsync = 0, mem_ack = 0;
    logic [15:0] mem_data = '0;
    logic mem_req, underflow;
    logic [AW-1:0] mem_addr;
    logic [3:0] pix_a, pix_r, pix_g, pix_b;
    logic [15:0] pix;

    logic f_flush = 0, f_push = 0, f_pop = 0;
    logic [15:0] f_din = '0, f_dout;
    logic f_full, f_empty;
    logic [3:0] f_count;

    int checks = 0, errors = 0;
    int lat = 3, step = 2, pop_k = 0;
    logic [15:0] seed;
    int strobes[$];
    logic [15:0] q[$];
    bit pend = 0, prev_req = 0;
    int cnt = 0;
    logic [AW-1:0] paddr;

    assign pix = {pix_a, pix_b, pix_g, pix_r};

    overlay_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .lowres(lowres),
        .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank), .vsync(vsync),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .pix_a(pix_a), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .underflow(underflow)
    );

    overlay_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo_solo (
        .clk(clk), .reset_n(reset_n), .flush(f_flush), .push(f_push), .pop(f_pop),
        .din(f_din), .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // SDRAM image: distinct word per address (odd multiplier is injective).
    function automatic logic [15:0] word_at(input int a);
        logic [15:0] a16;
        a16 = a[15:0];
        return seed ^ (a16 * 16'h2F1B);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SDRAM model: answers each strobe after 'lat' cycles and logs addresses.
    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 0; mem_ack = 0; prev_req = 0;
        end else begin
            mem_ack = 0;
            if (pend) begin
                if (cnt <= 1) begin
                    mem_ack = 1; mem_data = word_at(int'(paddr)); pend = 0;
                end else cnt--;
            end
            if (mem_req) begin
                check("one_outstanding", {31'b0, pend}, 0);
                check("req_one_cycle", {31'b0, prev_req}, 0);
                strobes.push_back(int'(mem_addr));
                pend = 1; cnt = lat; paddr = mem_addr;
            end
            prev_req = mem_req;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one(input int gap);
        @(negedge clk); ce_pix = 1; hblank = 0; vblank = 0;
        @(negedge clk); ce_pix = 0; hblank = 1; vblank = 1;
        check("pix_seq", {16'b0, pix}, {16'b0, word_at((pop_k * step) % (1 << AW))});
        pop_k++;
        tick(gap);
    endtask

    task automatic vsync_pulse();
        @(negedge clk); vsync = 1; ce_pix = 1;
        @(posedge clk); #1;
        strobes.delete(); pop_k = 0;
        check("flush_on_vsync", {28'b0, u_dut.u_fifo.count}, 0);
        @(negedge clk); vsync = 0; ce_pix = 1;
        @(negedge clk); ce_pix = 0;
    endtask

    initial begin
        int n0;
        bit ok;
        seed = 16'($urandom);

        // Reset state
        tick(3);
        check("rst_mem_req", {31'b0, mem_req}, 0);
        check("rst_mem_addr", {26'b0, mem_addr}, 0);
        check("rst_pix", {16'b0, pix}, 0);
        check("rst_underflow", {31'b0, underflow}, 0);
        reset_n = 1;

        // Test 1: fill to 8 words at step 2, first pixel is word 0
        enable = 1; lowres = 0; lat = 3; step = 2;
        tick(100);
        check("t1_nstrobes", strobes.size(), 8);
        for (int i = 0; i < 8; i++)
            check("t1_addr", (i < strobes.size()) ? strobes[i] : -1, 2 * i);
        check("t1_occ", {28'b0, u_dut.u_fifo.count}, 8);
        pop_one(0);
        tick(4);
        check("t1_pix_hold", {16'b0, pix}, {16'b0, word_at(0)});
        for (int i = 0; i < 3; i++) pop_one($urandom_range(6, 9));

        // Test 2: lowres, new frame, addresses step by 4
        lowres = 1; step = 4;
        vsync_pulse();
        tick(100);
        for (int i = 0; i < 4; i++)
            check("t2_addr", (i < strobes.size()) ? strobes[i] : -1, 4 * i);
        for (int i = 0; i < 4; i++) pop_one($urandom_range(6, 9));

        // Test 3: frame restart while a read is outstanding
        lat = 20;
        n0 = strobes.size();
        pop_one(0);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick(1);
            ok = (strobes.size() > n0);
        end
        check("t3_strobe_seen", {31'b0, ok}, 1);
        tick(3);
        check("t3_occ_before", {31'b0, u_dut.u_fifo.count != 0}, 1);
        lowres = 0; step = 2;
        vsync_pulse();
        tick(300);
        check("t3_first_addr", (strobes.size() > 0) ? strobes[0] : -1, 0);
        pop_one(8);
        pop_one(8);

        // Disable clears outputs and restarts at address 0
        @(negedge clk); enable = 0;
        @(negedge clk);
        check("dis_pix", {16'b0, pix}, 0);
        check("dis_addr", {26'b0, mem_addr}, 0);
        check("dis_occ", {28'b0, u_dut.u_fifo.count}, 0);
        strobes.delete(); pop_k = 0; lat = 3;
        tick(50);
        enable = 1;

        // Test 6: long run through the top of the address space
        tick(100);
        for (int i = 0; i < 40; i++) pop_one($urandom_range(5, 8));
        check("wrap_reached", {31'b0, strobes.size() > 33}, 1);
        for (int i = 0; i < strobes.size(); i++)
            check("wrap_addr", strobes[i], (2 * i) % (1 << AW));

        // Test 4: slow memory, continuous pixel demand starves the buffer
        lat = 40;
        vsync_pulse();
        tick(700);
        check("t4_occ_full", {28'b0, u_dut.u_fifo.count}, 8);
        @(negedge clk); ce_pix = 1; hblank = 0; vblank = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                check("t4_pix", {16'b0, pix}, {16'b0, word_at(2 * k)});
                check("t4_no_underflow", {31'b0, underflow}, 0);
            end else begin
                check("t4_starved_pix", {16'b0, pix}, 0);
                check("t4_underflow", {31'b0, underflow}, 1);
            end
        end
        ce_pix = 0; hblank = 1; vblank = 1;
        tick(5);
        check("t4_underflow_sticky", {31'b0, underflow}, 1);
        @(negedge clk); enable = 0;
        @(negedge clk);
        check("t4_underflow_clear", {31'b0, underflow}, 0);
        enable = 1;

        // Test 5: buffer full with push and pop together
        @(negedge clk); f_flush = 1;
        @(negedge clk); f_flush = 0;
        for (int i = 0; i < 8; i++) begin
            f_push = 1; f_din = 16'($urandom); q.push_back(f_din);
            @(negedge clk);
        end
        check("t5_full", {31'b0, f_full}, 1);
        check("t5_count8", {28'b0, f_count}, 8);
        f_din = 16'($urandom);
        @(negedge clk);
        check("t5_push_at_full_rejected", {28'b0, f_count}, 8);
        for (int i = 0; i < 4; i++) begin
            f_pop = 1; f_din = 16'($urandom);
            check("t5_head", {16'b0, f_dout}, {16'b0, q[0]});
            @(negedge clk);
            void'(q.pop_front());
            q.push_back(f_din);
            check("t5_count_steady", {28'b0, f_count}, 8);
        end
        f_push = 0; f_pop = 1;
        for (int i = 0; i < 8; i++) begin
            check("t5_drain", {16'b0, f_dout}, {16'b0, q.pop_front()});
            @(negedge clk);
        end
        f_pop = 0;
        check("t5_empty", {31'b0, f_empty}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlay_fetch.md
OVERLAY_FETCH -- requirements
Module: overlay_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, prefetch buffer depth in words (power of two, minimum 4).
REQ-002 SHALL have parameter ADDR_W, default 25, SDRAM byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: an overlay image is loaded and use of the background is permitted.
REQ-006 SHALL have port lowres, input, 1 bit: low-resolution mode, which changes the address step to 4.
REQ-007 SHALL have port ce_pix, input, 1 bit: pixel clock enable.
REQ-008 SHALL have ports hblank and vblank, input, 1 bit each: blanking signals. Active video is ~(hblank|vblank).
REQ-009 SHALL have port vsync, input, 1 bit: vertical sync. Its rising edge marks frame start.
REQ-010 SHALL have port mem_req, output, 1 bit: one-cycle read strobe to SDRAM.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: read address, held stable from the strobe until the matching ack.
REQ-012 SHALL have port mem_ack, input, 1 bit: mem_data is valid in this cycle.
REQ-013 SHALL have port mem_data, input, 16 bits: word packed as {a,b,g,r} at 4 bits per field.
REQ-014 SHALL have ports pix_a, pix_r, pix_g, pix_b, output, 4 bits each: the current overlay pixel.
REQ-015 SHALL have port underflow, output, 1 bit: sticky flag that the buffer was empty when a pixel was due.

Function
REQ-016 Fetch FSM SHALL have four states: IDLE, REQ, WAIT, DRAIN. At most one read SHALL be outstanding.
REQ-017 IDLE->REQ SHALL occur when enable=1 and FIFO occupancy < FIFO_DEPTH. Occupancy SHALL count the outstanding read.
REQ-018 REQ SHALL assert mem_req for exactly one cycle and then go to WAIT.
REQ-019 WAIT SHALL go to IDLE on mem_ack. The FIFO SHALL push mem_data, and mem_addr SHALL advance by 2 (lowres=0) or 4 (lowres=1).
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_W. Wrap from the maximum address to 0 SHALL be silent.
REQ-021 On a vsync rising edge (registered on ce_pix), the FIFO SHALL be flushed and mem_addr SHALL be set to 0.
REQ-022 If that vsync edge occurs in REQ or WAIT, the FSM SHALL go to DRAIN. DRAIN SHALL discard the next mem_ack without pushing, then return to IDLE.
REQ-023 If a vsync edge occurs in DRAIN, the FSM SHALL stay in DRAIN.
REQ-024 Pixel pop SHALL occur on a cycle where ce_pix=1, active video is true, and the FIFO is non-empty. The pix_* outputs SHALL update on the next clock edge (latency 1).
REQ-025 If a pop is due while the FIFO is empty, pix_* SHALL be driven to 0 and underflow SHALL be set. underflow SHALL be cleared only by reset or by enable falling.
REQ-026 Outside active video, pix_* SHALL hold their last value and no pop SHALL occur.
REQ-027 A push and a pop in the same cycle SHALL both occur, leaving occupancy unchanged. A push SHALL be allowed at full only if a pop occurs in the same cycle.
REQ-028 enable=0 SHALL force IDLE and flush the FIFO, with mem_addr set to 0 and pix_* set to 0.
REQ-029 If enable falls while in WAIT, the FSM SHALL go to DRAIN.
REQ-030 mem_ack received in IDLE or REQ SHALL be ignored.

Reset
REQ-031 On reset_n=0, all of the following SHALL be set asynchronously: FSM to IDLE, FIFO empty, mem_req=0, mem_addr=0, pix_*=0, underflow=0, and the registered vsync=0.
REQ-032 Deassertion of reset_n SHALL be synchronous to clk. The first mem_req SHALL be no earlier than 1 cycle after release.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the ARGB4444 field offsets, and the step constants 2 and 4.
REQ-034 The FIFO SHALL be a sub-module named overlay_fifo, parameterised by FIFO_DEPTH and width 16, with push/pop/full/empty/flush.

Verification
REQ-035 Test 1: reset, enable=1, SDRAM model returns ack 3 cycles after each strobe, lowres=0. Required: strobes to addresses 0, 2, 4 … stopping at 8 stored words. The first active ce_pix yields word 0 on pix_* one cycle later.
REQ-036 Test 2: lowres=1, 4 pixels consumed. Required: addresses 0, 4, 8, 12 …, and pixel data in address order.
REQ-037 Test 3: vsync rising edge while in WAIT. Required: the stale ack is dropped (no push), the next strobe is at address 0, and the FIFO is empty immediately after the edge.
REQ-038 Test 4: ack latency of 40 cycles with ce_pix every cycle during active video. Required: underflow=1 and pix_*=0 on the starved pixel.
REQ-039 Test 5: FIFO full with a push and a pop in the same cycle. Required: occupancy stays 8 and no data is lost, checked against the scoreboard.
REQ-040 Test 6: mem_addr preset near 2^25-2 via a long fetch run. Required: the next address is 0, with no glitch on mem_req.
